// File: rtl/sram_word_ctrl_if.sv
// Bus bundle between the MEM stage, the word sequencer and the 16-bit SRAM pads.
// slave  : the sequencer (sram_word_ctrl).
// master : whatever drives requests and models the SRAM (pipeline + pad side).
interface sram_word_ctrl_if;
    // MEM-stage request/response
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    // SRAM pad side
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_ce_n;

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready,
               sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n
    );

    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready,
               sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n
    );
endinterface

// File: rtl/sram_word_ctrl.sv
// sram_word_ctrl: splits one 32-bit load/store into two half-word accesses on a
// 16-bit asynchronous SRAM, each held for WAIT_CYCLES cycles, and stalls the
// pipeline through `ready` meanwhile.
// Optional build macro SRAM_ADDR_OFFSET_EN: rebases byte address 1024 to SRAM word 0.
module sram_word_ctrl #(
    parameter int WAIT_CYCLES = 2   // cycles per half-word phase, 1..15
) (
    input  logic            clk,
    input  logic            reset,  // synchronous, active-high
    sram_word_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_q, op_d;          // 1 = write
    logic [31:0] read_data_q, read_data_d;

    logic [31:0] wa;
    logic        phase_high;
    logic        unused_wa_bits;

    // Word address; the low two byte-address bits never reach the SRAM.
`ifdef SRAM_ADDR_OFFSET_EN
    assign wa = (bus.address - 32'd1024) >> 2;
`else
    assign wa = bus.address >> 2;
`endif
    assign unused_wa_bits = ^{wa[31:17], bus.address[1:0]};

    // State register: only the reset path and the next-state logic touch these flops.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= 1'b0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            read_data_q <= read_data_d;
        end
    end

    // Next-state: phase sequencing, op latch, and half-word read captures.
    always_comb begin
        // NOTE: hold-value defaults first, so no path leaves a signal unassigned (no latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        read_data_d = read_data_q;
        case (state_q)
            IDLE: begin
                if (bus.wr_en || bus.rd_en) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    op_d    = bus.wr_en;   // write wins when both are raised
                end
            end
            LOW: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    if (!op_q) read_data_d[15:0] = bus.sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HIGH: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!op_q) read_data_d[31:16] = bus.sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SRAM pins: driven only during the LOW/HIGH phases, idle-high strobes otherwise.
    always_comb begin
        phase_high      = (state_q == HIGH);
        bus.sram_addr   = '0;
        bus.sram_dq_out = '0;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_we_n   = 1'b1;
        bus.sram_oe_n   = 1'b1;
        bus.sram_ce_n   = 1'b1;
        if (state_q == LOW || state_q == HIGH) begin
            bus.sram_ce_n = 1'b0;
            bus.sram_addr = {wa[16:0], phase_high};
            if (op_q) begin
                bus.sram_dq_oe  = 1'b1;
                bus.sram_we_n   = 1'b0;
                bus.sram_dq_out = phase_high ? bus.write_data[31:16] : bus.write_data[15:0];
            end else begin
                bus.sram_oe_n = 1'b0;
            end
        end
    end

    // Pipeline handshake: a fresh request drops ready in the cycle it appears.
    assign bus.ready     = (state_q == IDLE && !bus.rd_en && !bus.wr_en) || (state_q == DONE);
    assign bus.read_data = read_data_q;

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Bench for sram_word_ctrl: table of word transactions on a WAIT_CYCLES=2 instance,
// plus hand sequences for back-to-back reads (WAIT_CYCLES=1) and reset mid-access.
module tb_sram_word_ctrl;

    localparam int W = 2;
`ifdef SRAM_ADDR_OFFSET_EN
    localparam logic [31:0] ADDR_BASE = 32'd1024;
`else
    localparam logic [31:0] ADDR_BASE = 32'd0;
`endif

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] off;      // byte offset from ADDR_BASE
        logic [31:0] wdata;
        logic [17:0] exp_sa;   // expected sram_addr during LOW
        logic [31:0] exp_rd;   // expected read_data in DONE
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    vec_t vecs [7];
    logic exp_rdy [13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                           1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    sram_word_ctrl_if if0 ();
    sram_word_ctrl_if if1 ();

    sram_word_ctrl #(.WAIT_CYCLES(W)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    sram_word_ctrl #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models: write on the clock while strobed, combinational read.
    logic [15:0] mem0 [64];
    logic [15:0] mem1 [64];

    always @(posedge clk) begin
        if (!if0.sram_ce_n && !if0.sram_we_n) mem0[if0.sram_addr[5:0]] <= if0.sram_dq_out;
        if (!if1.sram_ce_n && !if1.sram_we_n) mem1[if1.sram_addr[5:0]] <= if1.sram_dq_out;
    end

    assign if0.sram_dq_in = (!if0.sram_ce_n && !if0.sram_oe_n) ? mem0[if0.sram_addr[5:0]] : 16'h0000;
    assign if1.sram_dq_in = (!if1.sram_ce_n && !if1.sram_oe_n) ? mem1[if1.sram_addr[5:0]] : 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_pins(input string tag);
        check({tag, "_ce_n"}, if0.sram_ce_n, 1);
        check({tag, "_we_n"}, if0.sram_we_n, 1);
        check({tag, "_oe_n"}, if0.sram_oe_n, 1);
        check({tag, "_dq_oe"}, if0.sram_dq_oe, 0);
        check({tag, "_addr"}, if0.sram_addr, 0);
    endtask

    // Called at a negedge while dut0 is idle; returns at the DONE-cycle negedge.
    task automatic run_txn(input vec_t v);
        logic is_wr;
        is_wr = v.wr;
        if0.rd_en      = v.rd;
        if0.wr_en      = v.wr;
        if0.address    = ADDR_BASE + v.off;
        if0.write_data = v.wdata;
        #1;
        check("req_ready", if0.ready, 0);
        check("req_ce_n", if0.sram_ce_n, 1);
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < W; c++) begin
                @(posedge clk); @(negedge clk);
                check("ph_ready", if0.ready, 0);
                check("ph_ce_n", if0.sram_ce_n, 0);
                check("ph_addr", if0.sram_addr, v.exp_sa + 18'(p));
                if (is_wr) begin
                    check("wr_we_n", if0.sram_we_n, 0);
                    check("wr_dq_oe", if0.sram_dq_oe, 1);
                    check("wr_oe_n", if0.sram_oe_n, 1);
                    check("wr_dq", if0.sram_dq_out, (p == 1) ? v.wdata[31:16] : v.wdata[15:0]);
                end else begin
                    check("rd_we_n", if0.sram_we_n, 1);
                    check("rd_dq_oe", if0.sram_dq_oe, 0);
                    check("rd_oe_n", if0.sram_oe_n, 0);
                end
            end
        end
        @(posedge clk); @(negedge clk);
        check("done_ready", if0.ready, 1);
        check_idle_pins("done");
        check("done_rdata", if0.read_data, v.exp_rd);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{1'b0, 1'b1, 32'h10,        32'hDEADBEEF, 18'd8, 32'h00000000};
        vecs[1] = '{1'b1, 1'b0, 32'h10,        32'h00000000, 18'd8, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b1, 32'h04,        32'h12345678, 18'd2, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b1, 32'h00,        32'hCAFEF00D, 18'd0, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 1'b0, 32'h04,        32'h00000000, 18'd2, 32'h12345678};
        vecs[5] = '{1'b1, 1'b0, 32'h00,        32'h00000000, 18'd0, 32'hCAFEF00D};
        vecs[6] = '{1'b1, 1'b0, 32'h0008_0013, 32'h00000000, 18'd8, 32'hDEADBEEF};

        reset = 1'b1;
        if0.rd_en = 1'b0; if0.wr_en = 1'b0; if0.address = '0; if0.write_data = '0;
        if1.rd_en = 1'b0; if1.wr_en = 1'b0; if1.address = '0; if1.write_data = '0;

        // Reset values
        @(posedge clk); @(negedge clk);
        check("rst_ready", if0.ready, 1);
        check("rst_rdata", if0.read_data, 0);
        check("rst_dq_out", if0.sram_dq_out, 0);
        check_idle_pins("rst");
        if0.rd_en = 1'b1;
        #1;
        check("rst_ready_req", if0.ready, 0);
        if0.rd_en = 1'b0;
        reset = 1'b0;
        @(posedge clk); @(negedge clk);

        // Table-driven transactions, each followed by one quiet idle cycle
        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i]);
            if0.rd_en = 1'b0;
            if0.wr_en = 1'b0;
            @(posedge clk); @(negedge clk);
            check("post_ready", if0.ready, 1);
            check("post_rdata", if0.read_data, vecs[i].exp_rd);
        end

        // WAIT_CYCLES=1: write, then two back-to-back reads of the same word
        if1.wr_en      = 1'b1;
        if1.address    = ADDR_BASE + 32'h08;
        if1.write_data = 32'hA5A55A5A;
        for (int k = 0; k < 13; k++) begin
            if (k > 0) begin
                @(posedge clk); @(negedge clk);
            end else begin
                #1;
            end
            check("b2b_ready", if1.ready, exp_rdy[k]);
            if (k == 1) check("b2b_addr_lo", if1.sram_addr, 4);
            if (k == 2) check("b2b_addr_hi", if1.sram_addr, 5);
            if (k == 5) check("b2b_oe_n", if1.sram_oe_n, 0);
            if (k == 7 || k == 11) check("b2b_rdata", if1.read_data, 32'hA5A55A5A);
            if (k == 3) begin
                if1.wr_en = 1'b0;
                if1.rd_en = 1'b1;
            end
            if (k == 11) if1.rd_en = 1'b0;
        end

        // Reset during the LOW phase of a write
        if0.wr_en      = 1'b1;
        if0.address    = ADDR_BASE + 32'h10;
        if0.write_data = 32'h11112222;
        @(posedge clk); @(negedge clk);
        check("mid_we_n_low", if0.sram_we_n, 0);
        reset     = 1'b1;
        if0.wr_en = 1'b0;
        @(posedge clk); @(negedge clk);
        check("mid_rst_rdata", if0.read_data, 0);
        check("mid_rst_dq_out", if0.sram_dq_out, 0);
        check("mid_rst_ready", if0.ready, 1);
        check_idle_pins("mid_rst");
        reset = 1'b0;
        @(posedge clk); @(negedge clk);
        check("after_rst_ce_n", if0.sram_ce_n, 1);
        check("after_rst_we_n", if0.sram_we_n, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
